// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
// Holds the FSM state encoding and the default operand width.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester (master) and serial_add_ctrl (slave).
// Operands and start are sampled by the slave only while it is idle.
interface serial_add_ctrl_if #(
  parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, op_a, op_b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output busy, done, result, cout, ovf
  );

endinterface

// File: rtl/serial_add_ctrl_alu.sv
// 1-bit full adder used as the serial datapath of serial_add_ctrl.
// Purely combinational; no latency, no backpressure.
module serial_add_ctrl_alu (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial A+B / A-B: one bit per clock through a single full adder, LSB first.
// Latency WIDTH+1 edges from the start edge to done; requests ignored while busy.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic sum_bit;
  logic carry_out;

  serial_add_ctrl_alu alu (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .s    (sum_bit),
    .cout (carry_out)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          sa_d    = bus.op_a;
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          sb_d    = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d = bus.sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        result_d = {sum_bit, result_q[WIDTH-1:1]};
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        carry_d  = carry_out;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cout_d  = carry_out;
          ovf_d   = carry_q ^ carry_out;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sa_q     <= '0;
      sb_q     <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, {ovf, cout, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    int ua, ub, sa, sb, ures, sres;
    logic c, o;
    logic [W-1:0] r;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    if (s) begin
      ures = ua - ub;
      sres = sa - sb;
      c    = (ua >= ub);
    end else begin
      ures = ua + ub;
      sres = sa + sb;
      c    = (ures >= (1 << W));
    end
    r = ures[W-1:0];
    o = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
    return {o, c, r};
  endfunction

  // One operation; operands are scrambled while it runs, which must not matter.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input string tag);
    logic [W+1:0] exp;
    int edges;
    bit seen;
    exp = model(a, b, s);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.sub   = s;
    @(posedge clk);
    edges = 1;
    seen  = 0;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, ".busy_run"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen = 1;
        break;
      end
      bus.op_a = W'($urandom);
      bus.op_b = W'($urandom);
      bus.sub  = 1'($urandom);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, 32'(edges), 32'(W + 1));
    check({tag, ".result"}, 32'(bus.result), 32'(exp[W-1:0]));
    check({tag, ".cout"}, 32'(bus.cout), 32'(exp[W]));
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(exp[W+1]));
    @(negedge clk);
    check({tag, ".idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
    check({tag, ".hold"}, 32'(bus.result), 32'(exp[W-1:0]));
  endtask

  initial begin
    int ndone, prev;
    logic [W-1:0] ra, rb;
    logic rs;
    errors = 0;
    checks = 0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.outs", {27'd0, bus.busy, bus.done, bus.cout, bus.ovf, 1'b0},
          32'd0);
    check("reset.result", 32'(bus.result), 32'd0);
    rst_n = 1'b1;

    do_op(8'h05, 8'h03, 1'b0, "add_5_3");
    do_op(8'hFF, 8'h01, 1'b0, "add_ff_1");
    do_op(8'h7F, 8'h01, 1'b0, "add_7f_1");
    do_op(8'h05, 8'h07, 1'b1, "sub_5_7");
    do_op(8'h80, 8'h01, 1'b1, "sub_80_1");
    do_op(8'h00, 8'h00, 1'b1, "sub_0_0");

    // New request mid-run must be dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 8'h11; bus.op_b = 8'h22; bus.sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.op_a = 8'hAA; bus.op_b = 8'h55; bus.sub = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        ndone++;
        check("ignore.result", 32'(bus.result), 32'h33);
      end
      @(negedge clk);
    end
    check("ignore.done_count", 32'(ndone), 32'd1);

    // Reset mid-run aborts with no done.
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 8'h5A; bus.op_b = 8'h33; bus.sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.outs", {27'd0, bus.busy, bus.done, bus.cout, bus.ovf, 1'b0}, 32'd0);
    check("abort.result", 32'(bus.result), 32'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      if (bus.done) ndone++;
    end
    check("abort.no_done", 32'(ndone), 32'd0);
    do_op(8'h01, 8'h01, 1'b0, "after_abort");

    // Start held high: one op every 10 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 8'h10; bus.op_b = 8'h20; bus.sub = 1'b0;
    ndone = 0;
    prev  = -1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        check("b2b.result", 32'(bus.result), 32'h30);
        if (prev >= 0) check("b2b.spacing", 32'(c - prev), 32'd10);
        prev = c;
      end
    end
    bus.start = 1'b0;
    check("b2b.count", 32'(ndone), 32'd3);
    repeat (12) @(negedge clk);

    for (int k = 0; k < 20; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      do_op(ra, rb, rs, $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
